// File: rtl/tt_cnt_pattern_checker.sv
// rtl/tt_cnt_pattern_checker.sv - lock/error checker for an incrementing counter pattern
module tt_cnt_pattern_checker #(
   parameter int WIDTH      = 8,
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             clr_err,
   output logic             locked,
   output logic [1:0]       state_o,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic [WIDTH-1:0] expected_o
);

   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(LOSS_COUNT + 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ACQUIRE = 2'b01,
      LOCKED  = 2'b10,
      LOST    = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  prev_q, prev_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic              err_pulse_q, err_pulse_d;
   logic [WIDTH-1:0]  prev_inc;
   logic              step_ok;

   assign prev_inc = prev_q + 1'b1;
   assign step_ok  = (data_in == prev_inc);

   // State and counters; reset clears everything without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         run_q       <= '0;
         miss_q      <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         run_q       <= run_d;
         miss_q      <= miss_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   // Next-state: clear is applied before counting so clear+error yields 1.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      run_d       = run_q;
      miss_d      = miss_q;
      err_pulse_d = 1'b0;
      err_cnt_d   = clr_err ? '0 : err_cnt_q;
      if (en) begin
         case (state_q)
            IDLE, LOST: begin
               prev_d  = data_in;
               run_d   = '0;
               state_d = ACQUIRE;
            end
            ACQUIRE: begin
               prev_d = data_in;
               if (step_ok) begin
                  run_d = run_q + 1'b1;
                  if (run_q == RUN_LAST) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end else begin
                  run_d = '0;
               end
            end
            LOCKED: begin
               // Reference free-runs so a single bad word costs one error only.
               prev_d = prev_inc;
               if (step_ok) begin
                  miss_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  if (!(&err_cnt_d)) err_cnt_d = err_cnt_d + 1'b1;
                  miss_d = miss_q + 1'b1;
                  if (miss_q == MISS_LAST) state_d = LOST;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign state_o    = state_q;
   assign locked     = (state_q == LOCKED);
   assign err_pulse  = err_pulse_q;
   assign err_cnt    = err_cnt_q;
   assign expected_o = (state_q == LOCKED) ? prev_inc : prev_q;

endmodule

// File: tb/tb_tt_cnt_pattern_checker.sv
// tb/tb_tt_cnt_pattern_checker.sv - self-checking bench for tt_cnt_pattern_checker
module tb_tt_cnt_pattern_checker;

   localparam int WIDTH = 8;
   localparam int LOCK_COUNT = 4;
   localparam int LOSS_COUNT = 3;
   localparam int ERR_W = 4;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             clr_err = 1'b0;
   logic             locked;
   logic [1:0]       state_o;
   logic             err_pulse;
   logic [ERR_W-1:0] err_cnt;
   logic [WIDTH-1:0] expected_o;

   int checks = 0;
   int errors = 0;

   // reference model: 0 idle, 1 acquiring, 2 locked, 3 lost
   int m_state, m_prev, m_run, m_miss, m_err, m_pulse;

   tt_cnt_pattern_checker #(
      .WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(ERR_W)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr_err(clr_err),
      .locked(locked), .state_o(state_o), .err_pulse(err_pulse),
      .err_cnt(err_cnt), .expected_o(expected_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int nxt();
      return (m_prev + 1) % 256;
   endfunction

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_run = 0; m_miss = 0; m_err = 0; m_pulse = 0;
   endtask

   task automatic model_step(input int e, input int d, input int c);
      int good;
      good = (d == nxt());
      m_pulse = 0;
      if (c) m_err = 0;
      if (e) begin
         if (m_state == 0 || m_state == 3) begin
            m_prev = d; m_run = 0; m_state = 1;
         end else if (m_state == 1) begin
            if (good) begin
               m_run++;
               if (m_run == LOCK_COUNT) begin m_state = 2; m_miss = 0; end
            end else m_run = 0;
            m_prev = d;
         end else begin
            if (good) m_miss = 0;
            else begin
               m_pulse = 1;
               if (m_err < ERR_MAX) m_err++;
               m_miss++;
               if (m_miss == LOSS_COUNT) m_state = 3;
            end
            m_prev = nxt();
         end
      end
   endtask

   task automatic check_all();
      chk("state", int'(state_o), m_state);
      chk("locked", int'(locked), (m_state == 2) ? 1 : 0);
      chk("err_pulse", int'(err_pulse), m_pulse);
      chk("err_cnt", int'(err_cnt), m_err);
      chk("expected_o", int'(expected_o), (m_state == 2) ? nxt() : m_prev);
   endtask

   // one clock: inputs applied while clk is low, outputs checked on the falling edge
   task automatic cycle(input int e, input int d, input int c);
      en = e[0]; data_in = d[WIDTH-1:0]; clr_err = c[0];
      @(posedge clk);
      model_step(e, d, c);
      @(negedge clk);
      check_all();
   endtask

   task automatic good_word();
      cycle(1, nxt(), 0);
   endtask

   task automatic bad_word();
      cycle(1, nxt() ^ $urandom_range(1, 255), 0);
   endtask

   initial begin
      model_reset();
      #2;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // acquire on 0x10..0x14
      cycle(1, 8'h10, 0);
      chk("acq_first_state", int'(state_o), 1);
      for (int v = 8'h11; v <= 8'h14; v++) cycle(1, v, 0);
      chk("acq_locked", int'(locked), 1);
      chk("acq_err", int'(err_cnt), 0);

      // run up through the wrap
      for (int v = 8'h15; v <= 8'hFD; v++) cycle(1, v, 0);
      cycle(1, 8'hFE, 0); cycle(1, 8'hFF, 0); cycle(1, 8'h00, 0); cycle(1, 8'h01, 0);
      chk("wrap_expected", int'(expected_o), 8'h02);
      chk("wrap_err", int'(err_cnt), 0);

      // single glitch
      for (int v = 8'h02; v <= 8'h3F; v++) cycle(1, v, 0);
      chk("glitch_exp40", int'(expected_o), 8'h40);
      cycle(1, 8'h99, 0);
      chk("glitch_pulse", int'(err_pulse), 1);
      cycle(1, 8'h41, 0);
      chk("glitch_pulse_gone", int'(err_pulse), 0);
      cycle(1, 8'h42, 0);
      chk("glitch_cnt", int'(err_cnt), 1);
      chk("glitch_locked", int'(locked), 1);

      // loss and reacquire
      for (int i = 0; i < 3; i++) bad_word();
      chk("loss_state", int'(state_o), 3);
      chk("loss_cnt", int'(err_cnt), 4);
      cycle(1, 8'h80, 0);
      chk("reacq_state", int'(state_o), 1);
      for (int v = 8'h81; v <= 8'h84; v++) cycle(1, v, 0);
      chk("reacq_locked", int'(locked), 1);
      cycle(1, 8'h85, 0);
      chk("reacq_cnt", int'(err_cnt), 4);

      // en gaps
      for (int i = 0; i < 10; i++) cycle(0, $urandom_range(0, 255), 0);
      cycle(1, 8'h86, 0);
      chk("gap_state", int'(state_o), 2);
      chk("gap_cnt", int'(err_cnt), 4);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         int e, d, c;
         e = ($urandom_range(0, 9) < 8) ? 1 : 0;
         d = ($urandom_range(0, 9) < 8) ? nxt() : $urandom_range(0, 255);
         c = ($urandom_range(0, 19) == 0) ? 1 : 0;
         cycle(e, d, c);
      end

      // saturation with ERR_W=4
      for (int i = 0; i < 6; i++) good_word();
      cycle(1, nxt(), 1);
      chk("sat_pre_locked", int'(locked), 1);
      chk("sat_pre_cnt", int'(err_cnt), 0);
      for (int i = 0; i < 10; i++) begin
         bad_word(); bad_word(); good_word();
      end
      chk("sat_cnt", int'(err_cnt), 15);
      cycle(1, nxt() ^ 8'h5A, 1);
      chk("clr_plus_err", int'(err_cnt), 1);
      chk("clr_plus_err_pulse", int'(err_pulse), 1);
      good_word();

      // asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("arst_locked", int'(locked), 0);
      chk("arst_cnt", int'(err_cnt), 0);
      chk("arst_state", int'(state_o), 0);
      chk("arst_expected", int'(expected_o), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) good_word();
      chk("post_rst_locked", int'(locked), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
